// File: rtl/uart_tx.sv
// sync_fifo: small generic FIFO holding bytes ahead of the serialiser.
// Latency: a pushed entry is visible at pop_dat/pop_vld the cycle after the push edge.
// Backpressure: push_rdy is high iff count < DEPTH; a same-cycle pop never frees a slot for a push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_rdy,
    output logic             pop_vld,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign push_rdy = (count < DEPTH_C);
    assign pop_vld  = (count != '0);
    assign pop_dat  = mem[rd_ptr];
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_rdy && pop_vld;

    // Storage array: written only on an accepted push, so held data is immune to input changes.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally (power-of-2 depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// uart_tx: 8N1 serial transmitter fed from a small holding FIFO.
// Latency: TxD falls 2 clocks after the accepting edge when idle with an empty FIFO.
// Backpressure: o_txReady low while the FIFO is full; offers made while low are ignored.
module uart_tx #(
    parameter int clk_freq   = 100_000_000,
    parameter int baud_rate  = 9_600,
    parameter int fifo_depth = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       i_txValid,
    output logic       o_txReady,
    output logic       TxD,
    output logic       o_busy,
    output logic       o_txDone
);
    localparam int div_bit = clk_freq / baud_rate;
    localparam int CW      = (div_bit > 1) ? $clog2(div_bit) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(div_bit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          txd_n;
    logic          done_n;
    logic          bit_end;
    logic          fifo_vld;
    logic          fifo_pop;
    logic [7:0]    fifo_dat;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (i_txValid),
        .push_dat (TxData),
        .push_rdy (o_txReady),
        .pop_vld  (fifo_vld),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_dat)
    );

    assign bit_end = (baud_cnt == BIT_LAST);
    assign o_busy  = (state != IDLE) || fifo_vld;

    // Next-state, bit sequencing and line value; TxD/o_txDone are registered one cycle behind state.
    always_comb begin
        state_n    = state;
        baud_cnt_n = bit_end ? '0 : baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        fifo_pop   = 1'b0;
        txd_n      = 1'b1;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (fifo_vld) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_dat;
                    state_n  = START;
                end
            end
            START: begin
                txd_n = 1'b0;
                if (bit_end) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                txd_n = shift[0];
                if (bit_end) begin
                    shift_n   = shift >> 1;
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                txd_n = 1'b1;
                if (bit_end) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            TxD      <= 1'b1;
            o_txDone <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            TxD      <= txd_n;
            o_txDone <= done_n;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized and directed stimulus with a scoreboard of accepted bytes.
// A line monitor reconstructs each 8N1 frame from TxD and compares it to the queue head.
// div_bit = 40/10 = 4 clocks per bit, 40 clocks per frame.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] TxData = 8'h00;
    logic       i_txValid = 1'b0;
    logic       o_txReady;
    logic       TxD;
    logic       o_busy;
    logic       o_txDone;

    uart_tx #(
        .clk_freq   (40),
        .baud_rate  (10),
        .fifo_depth (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .TxData    (TxData),
        .i_txValid (i_txValid),
        .o_txReady (o_txReady),
        .TxD       (TxD),
        .o_busy    (o_busy),
        .o_txDone  (o_txDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];
    int         done_q[$];
    int         accept_cyc = 0;
    bit         mon_active = 1'b0;
    int         mon_i = 0;
    int         stray_done = 0;
    logic [9:0] frame;
    logic [7:0] cur;
    int         bad;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    // Line monitor: frame = start 0, data LSB first, stop 1; each bit 4 samples; done only on sample 39.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                continue;
            end
            if (!mon_active) begin
                if (o_txDone) stray_done++;
                if (TxD === 1'b0) begin
                    mon_active = 1'b1;
                    mon_i = 0;
                    bad = 0;
                    start_q.push_back(cyc);
                    chk("frame_expected", int'(exp_q.size() > 0), 1);
                    cur = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
                    frame = {1'b1, cur, 1'b0};
                end
            end
            if (mon_active) begin
                if (TxD !== frame[mon_i/4]) bad++;
                if (o_txDone !== (mon_i == 39)) bad++;
                if (mon_i == 39) begin
                    done_q.push_back(cyc);
                    chk($sformatf("frame_%02h_errors", cur), bad, 0);
                    mon_active = 1'b0;
                end else begin
                    mon_i++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present b and hold it until accepted; valid stays high on return.
    task automatic push(input logic [7:0] b);
        int  t;
        logic rdy;
        t = 0;
        TxData = b;
        i_txValid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = o_txReady;
            @(posedge clk);
            if (rdy && !reset) begin
                exp_q.push_back(b);
                #1;
                accept_cyc = cyc;
                break;
            end
            #1;
            t++;
            if (t > 500) begin
                chk("push_timeout", t, 0);
                break;
            end
        end
    endtask

    task automatic release_in();
        i_txValid = 1'b0;
        TxData = 8'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((o_busy || mon_active) && t < 3000) begin
            step();
            t++;
        end
        step();
        chk("drain_busy", int'(o_busy || mon_active), 0);
    endtask

    task automatic clear_log();
        start_q.delete();
        done_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int acc[6];
    int cnt;
    int t;
    int ndone;

    initial begin
        // Reset with a push offered: it must be discarded.
        reset = 1'b1;
        TxData = 8'h5A;
        i_txValid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        i_txValid = 1'b0;
        @(negedge clk);
        chk("reset_txd", int'(TxD), 1);
        chk("reset_ready", int'(o_txReady), 1);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_txDone), 0);
        step();

        // Single frame 0xA5: latency and done position.
        clear_log();
        push(8'hA5);
        release_in();
        drain();
        chk("a5_frames", start_q.size(), 1);
        if (start_q.size() == 1 && done_q.size() == 1) begin
            chk("a5_latency", start_q[0] - accept_cyc, 2);
            chk("a5_done_pos", done_q[0] - start_q[0], 39);
        end
        chk("a5_busy_after", int'(o_busy), 0);

        // Hold valid with 0x01..0x06: five accepted at once, sixth waits for a slot.
        clear_log();
        for (int i = 0; i < 6; i++) begin
            push(8'(i + 1));
            acc[i] = accept_cyc;
            if (i == 4) begin
                @(negedge clk);
                chk("full_ready_low", int'(o_txReady), 0);
            end
        end
        release_in();
        drain();
        chk("hold_first5_consecutive", acc[4] - acc[0], 4);
        chk("hold_frames", start_q.size(), 6);
        if (start_q.size() >= 2) chk("hold_6th_accept", acc[5], start_q[1]);
        cnt = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 41) cnt++;
        chk("hold_gaps", cnt, 0);

        // Full FIFO ignores 0x77 until re-presented with room.
        clear_log();
        for (int i = 0; i < 5; i++) push(8'($urandom));
        TxData = 8'h77;
        i_txValid = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (o_txReady) cnt++;
        end
        chk("full_no_ready", cnt, 0);
        step();
        release_in();
        drain();
        chk("full_frames", start_q.size(), 5);
        push(8'h77);
        release_in();
        drain();
        chk("full_77_frames", start_q.size(), 6);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        clear_log();
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        release_in();
        t = 0;
        while (!(mon_active && mon_i == 17) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reached_bit3", int'(mon_active && mon_i == 17), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_txd_idle", int'(TxD), 1);
        chk("mid_busy", int'(o_busy), 0);
        ndone = done_q.size() + stray_done;
        repeat (100) step();
        chk("mid_no_done", done_q.size() + stray_done, ndone);
        chk("mid_no_frame", start_q.size(), 1);
        push(8'h81);
        release_in();
        drain();
        chk("mid_clean_frame", done_q.size(), 1);

        // 0x00 then 0xFF back to back: done pulses 41 apart.
        clear_log();
        push(8'h00);
        push(8'hFF);
        release_in();
        drain();
        chk("pair_dones", done_q.size(), 2);
        if (done_q.size() == 2) chk("pair_done_gap", done_q[1] - done_q[0], 41);

        // Random traffic with random idle gaps.
        clear_log();
        for (int i = 0; i < 30; i++) begin
            release_in();
            repeat ($urandom_range(0, 3)) step();
            push(8'($urandom));
        end
        release_in();
        drain();
        chk("rand_frames", start_q.size(), 30);
        cnt = 0;
        for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] < 41) cnt++;
        chk("rand_min_gap", cnt, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        chk("stray_done", stray_done, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
